key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter NKEYS, default 4, number of push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles before a change is accepted; legal range 1 to 2^24-1.
REQ-003 Parameter KEY_ACTIVE_LOW, default 1; 1 means keysRaw reads 0 when a key is pressed.
REQ-004 Parameter REPEAT_DELAY, default 25000000, cycles held before the first auto-repeat pulse.
REQ-005 Parameter REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeat pulses.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 keysRaw  input  NKEYS  asynchronous pad levels from the board buttons.
REQ-009 keys  output  NKEYS  debounced level, active-high pressed; drives the keys input of the memory-mapped key device.
REQ-010 keyPress  output  NKEYS  one-cycle pulse per accepted press (and per repeat, when enabled).
REQ-011 keyRelease  output  NKEYS  one-cycle pulse per accepted release.

Function
REQ-012 Each keysRaw bit SHALL pass through a 2-flop synchronizer, then be inverted if KEY_ACTIVE_LOW=1, giving the synced level s[i].
REQ-013 Each key SHALL run an independent FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 RELEASED->PRESS_WAIT when s[i]=1; PRESSED->RELEASE_WAIT when s[i]=0; counter cleared on entry.
REQ-015 In a WAIT state the counter SHALL increment each cycle s[i] differs from keys[i]; a cycle where s[i] equals keys[i] returns to the stable state and clears the counter (glitch rejected, no pulse).
REQ-016 When the counter reaches DEBOUNCE_CYCLES, the FSM SHALL enter the new stable state, toggle keys[i] on that same edge, and clear the counter.
REQ-017 Latency: raw edge held stable -> keys[i] change exactly 2+DEBOUNCE_CYCLES cycles later.
REQ-018 keyPress[i] SHALL be high for exactly the cycle in which keys[i] first reads 1; keyRelease[i] likewise for the cycle in which keys[i] first reads 0.
REQ-019 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); the counter SHALL never wrap.
REQ-020 Keys SHALL be fully independent; simultaneous changes on several keys SHALL produce simultaneous pulses.
REQ-021 Bounce narrower than DEBOUNCE_CYCLES after synchronization SHALL cause no change on any output.

Reset
REQ-022 While reset is high on a clock edge, all FSMs SHALL go to RELEASED, counters and repeat timers clear, synchronizer flops load the released level, and keys, keyPress and keyRelease SHALL be 0 on the next cycle.
REQ-023 Reset mid-debounce or mid-press SHALL discard the pending change with no pulses; a key still held after reset is re-detected through the full 2+DEBOUNCE_CYCLES latency.

Configuration
REQ-024 Macro KEY_DEBOUNCER_AUTOREPEAT_EN defined: in PRESSED, a repeat timer SHALL emit an extra keyPress pulse REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles until leaving PRESSED; the timer SHALL keep running during RELEASE_WAIT and clear when the FSM returns to PRESSED.
REQ-025 Macro undefined: no repeat logic is synthesized, and exactly one keyPress pulse is emitted per accepted press.

Structure
REQ-026 Shared package key_pkg SHALL hold the FSM state typedef, the default DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD constants and the KEY_ACTIVE_LOW default.
REQ-027 One sub-module, key_debounce_cell (synchronizer, FSM, counter and optional repeat timer for one key), SHALL be instantiated NKEYS times by a generate loop.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, KEY_ACTIVE_LOW=1)
REQ-028 keysRaw[0] 1->0 held -> keys[0]=1 and keyPress[0] pulse exactly 6 cycles later; hold, then 0->1 -> keyRelease[0] pulse 6 cycles later.
REQ-029 keysRaw[1] low for 3 cycles then high -> keys, keyPress and keyRelease remain 0 throughout.
REQ-030 keysRaw[2] toggles every 2 cycles for 20 cycles then held low -> a single keyPress[2] pulse 6 cycles after the final edge.
REQ-031 All 4 keys pressed on the same cycle -> keyPress=4'hF for one cycle and keys=4'hF.
REQ-032 Reset asserted 2 cycles into PRESS_WAIT with the key held -> no pulse; keys=0 one cycle after reset; the press is accepted 6 cycles after reset deasserts.
REQ-033 With KEY_DEBOUNCER_AUTOREPEAT_EN, key 3 held for 25 cycles after acceptance -> keyPress[3] pulses at offsets 0, 10, 13, 16, 19 and 22; without the macro, a pulse at offset 0 only.

Source files
------------

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state type and default timing constants for the key debouncer
package key_pkg;

    typedef enum logic [1:0] {
        KEY_RELEASED     = 2'd0,
        KEY_PRESS_WAIT   = 2'd1,
        KEY_PRESSED      = 2'd2,
        KEY_RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;
    localparam int DEF_KEY_ACTIVE_LOW  = 1;

endpackage

// File: rtl/key_debounce_cell.sv
// rtl/key_debounce_cell.sv - one key: synchronizer, debounce FSM, counter, repeat timer under KEY_DEBOUNCER_AUTOREPEAT_EN
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Pad level of a key that is not pressed
    localparam logic          RAW_IDLE = (KEY_ACTIVE_LOW != 0);

    logic [1:0]    sync;
    logic          s;
    key_state_t    state;
    key_state_t    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          level_nx;
    logic          press_nx;
    logic          release_nx;
    logic          rpt_fire;

    // Two-flop synchronizer; reset loads the released pad level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= {2{RAW_IDLE}};
        end else begin
            sync <= {sync[0], raw};
        end
    end

    assign s = sync[1] ^ RAW_IDLE;

    // State, counter and registered level/pulse outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= KEY_RELEASED;
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            level         <= level_nx;
            press         <= press_nx | rpt_fire;
            release_pulse <= release_nx;
        end
    end

    // Next state: a change is accepted only after the counter has seen a full stable run
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        level_nx   = level;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        case (state)
            KEY_RELEASED: begin
                if (s) begin
                    state_nx = KEY_PRESS_WAIT;
                    cnt_nx   = '0;
                end
            end
            KEY_PRESS_WAIT: begin
                if (!s) begin
                    state_nx = KEY_RELEASED;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = KEY_PRESSED;
                    cnt_nx   = '0;
                    level_nx = 1'b1;
                    press_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            KEY_PRESSED: begin
                if (!s) begin
                    state_nx = KEY_RELEASE_WAIT;
                    cnt_nx   = '0;
                end
            end
            KEY_RELEASE_WAIT: begin
                if (s) begin
                    state_nx = KEY_PRESSED;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx   = KEY_RELEASED;
                    cnt_nx     = '0;
                    level_nx   = 1'b0;
                    release_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = KEY_RELEASED;
                cnt_nx   = '0;
                level_nx = 1'b0;
            end
        endcase
    end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_limit;
    logic          rpt_first;

    // First repeat waits the long delay, later ones the short period
    assign rpt_limit = rpt_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    assign rpt_fire  = (state == KEY_PRESSED) && (state_nx == KEY_PRESSED) && (rpt_cnt == rpt_limit);

    // Repeat timer: restarts on every entry to PRESSED, keeps counting through RELEASE_WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if ((state_nx == KEY_PRESSED) && (state != KEY_PRESSED)) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state == KEY_PRESSED) begin
            if (rpt_cnt == rpt_limit) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end else if ((state == KEY_RELEASE_WAIT) && (rpt_cnt != rpt_limit)) begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    // Repeat timing has no effect when auto-repeat is left out of the build
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - NKEYS independent push-button debouncers, auto-repeat under KEY_DEBOUNCER_AUTOREPEAT_EN
module key_debouncer
    import key_pkg::*;
#(
    parameter int NKEYS           = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] keysRaw,
    output logic [NKEYS-1:0] keys,
    output logic [NKEYS-1:0] keyPress,
    output logic [NKEYS-1:0] keyRelease
);

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_cell (
            .clk           (clk),
            .reset         (reset),
            .raw           (keysRaw[i]),
            .level         (keys[i]),
            .press         (keyPress[i]),
            .release_pulse (keyRelease[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - self-checking bench for key_debouncer
module tb_key_debouncer;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys_raw;
    logic [NK-1:0] keys;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [3:0] keys;
        logic [3:0] press;
        logic [3:0] rel;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        int         len;
        logic [3:0] end_keys;
    } seg_t;

    exp_t       exp_q[$];
    logic [3:0] hist[$];
    logic [3:0] keys_m = 4'h0;
    seg_t       segs[$];

    always #5 clk = ~clk;

    key_debouncer #(
        .NKEYS           (NK),
        .DEBOUNCE_CYCLES (DB),
        .KEY_ACTIVE_LOW  (1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .keysRaw    (keys_raw),
        .keys       (keys),
        .keyPress   (key_press),
        .keyRelease (key_release)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: a key toggles once DB+1 consecutive synced samples (sample taken
    // two edges earlier) all disagree with the current debounced level.
    task automatic tick(input logic rst, input logic [3:0] raw);
        exp_t       e;
        logic [3:0] prev;
        int         t;
        bit         all;
        reset    = rst;
        keys_raw = raw;
        hist.push_back(~raw);
        t    = hist.size() - 1;
        prev = keys_m;
        if (rst) begin
            hist[t] = 4'h0;
            if (t > 0) hist[t-1] = 4'h0;
            keys_m = 4'h0;
        end else if (t >= DB + 2) begin
            for (int i = 0; i < NK; i++) begin
                all = 1'b1;
                for (int j = t - 2 - DB; j <= t - 2; j++)
                    if (hist[j][i] == prev[i]) all = 1'b0;
                if (all) keys_m[i] = ~prev[i];
            end
        end
        e.keys  = keys_m;
        e.press = keys_m & ~prev;
        e.rel   = ~keys_m & prev;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("keys", 32'(keys), 32'(e.keys));
        check("keyRelease", 32'(key_release), 32'(e.rel));
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
        begin
            logic [3:0] pmask;
            pmask = ~e.keys | e.press;
            check("keyPress", 32'(key_press & pmask), 32'(e.press & pmask));
        end
`else
        check("keyPress", 32'(key_press), 32'(e.press));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         found;
        logic [24:0] seen;
        logic [24:0] exp_rep;

        segs.push_back('{1'b1, 4'hF, 3, 4'h0});
        segs.push_back('{1'b0, 4'hF, 4, 4'h0});
        segs.push_back('{1'b0, 4'hD, 3, 4'h0});
        segs.push_back('{1'b0, 4'hF, 10, 4'h0});
        for (int k = 0; k < 5; k++) begin
            segs.push_back('{1'b0, 4'hB, 2, 4'h0});
            segs.push_back('{1'b0, 4'hF, 2, 4'h0});
        end
        segs.push_back('{1'b0, 4'hB, 12, 4'h4});
        segs.push_back('{1'b0, 4'hF, 10, 4'h0});
        segs.push_back('{1'b0, 4'h0, 10, 4'hF});
        segs.push_back('{1'b0, 4'hF, 10, 4'h0});

        reset    = 1'b1;
        keys_raw = 4'hF;

        for (int s = 0; s < segs.size(); s++) begin
            for (int c = 0; c < segs[s].len; c++) tick(segs[s].rst, segs[s].raw);
            check($sformatf("seg%0d_end_keys", s), 32'(keys), 32'(segs[s].end_keys));
            if (s == 0) check("reset_outputs", 32'({keys, key_press, key_release}), 32'h0);
        end

        // Press latency on key 0, counted from the edge that captures the new pad level
        found = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            tick(1'b0, 4'hE);
            if (key_press[0]) found = k;
        end
        check("press_latency", 32'(found - 1), 32'(2 + DB));
        for (int k = 0; k < 3; k++) tick(1'b0, 4'hE);
        found = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            tick(1'b0, 4'hF);
            if (key_release[0]) found = k;
        end
        check("release_latency", 32'(found - 1), 32'(2 + DB));
        for (int k = 0; k < 6; k++) tick(1'b0, 4'hF);

        // Reset two cycles into PRESS_WAIT with the key still held
        for (int k = 0; k < 4; k++) tick(1'b0, 4'hE);
        tick(1'b1, 4'hE);
        check("reset_mid_wait", 32'({keys, key_press, key_release}), 32'h0);
        found = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            tick(1'b0, 4'hE);
            if (key_press[0]) found = k;
        end
        check("post_reset_latency", 32'(found - 1), 32'(2 + DB));
        for (int k = 0; k < 10; k++) tick(1'b0, 4'hF);

        // Auto-repeat pattern on key 3
        found = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            tick(1'b0, 4'h7);
            if (key_press[3]) found = k;
        end
        check("key3_accept", 32'(found - 1), 32'(2 + DB));
        seen    = '0;
        seen[0] = (found != 0);
        for (int off = 1; off < 25; off++) begin
            tick(1'b0, 4'h7);
            if (key_press[3]) seen[off] = 1'b1;
        end
        exp_rep    = '0;
        exp_rep[0] = 1'b1;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
        exp_rep[RD]          = 1'b1;
        exp_rep[RD + RP]     = 1'b1;
        exp_rep[RD + 2 * RP] = 1'b1;
        exp_rep[RD + 3 * RP] = 1'b1;
        exp_rep[RD + 4 * RP] = 1'b1;
`endif
        check("repeat_offsets", 32'(seen), 32'(exp_rep));
        for (int k = 0; k < 12; k++) tick(1'b0, 4'hF);
        check("final_keys", 32'(keys), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
